// File: rtl/configurations_pkg.sv
// Shared lane configuration: bus/vector sizing, memory-controller FSM state
// encoding and the default load-issue depth.
package configurations_pkg;

    localparam int unsigned DATA_WIDTH          = 32;
    localparam int unsigned VECTOR_LENGTH       = 32;
    localparam int unsigned MAX_OUTSTANDING_DEF = 4;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        ST_POP   = 3'd2,
        ST_WAIT  = 3'd3,
        ST_WRITE = 3'd4,
        DONE     = 3'd5
    } mem_ctrl_state_t;

    // Element-count width able to hold VECTOR_LENGTH*8 inclusive.
    function automatic int unsigned len_width(input int unsigned vlen);
        return $clog2(vlen * 8) + 1;
    endfunction

endpackage

// File: rtl/v_mem_addr_gen.sv
// Strided address generator shared by the load and store paths.
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   load_i         : capture base_i as current address and stride_i as stride
//   step_i         : advance current address by the captured stride
//   base_i         : first element byte address
//   stride_i       : unsigned byte stride
//   addr_o         : current address (registered)
module v_mem_addr_gen #(
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_i,
    input  logic                  step_i,
    input  logic [ADDR_WIDTH-1:0] base_i,
    input  logic [ADDR_WIDTH-1:0] stride_i,
    output logic [ADDR_WIDTH-1:0] addr_o
);

    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] stride_q, stride_d;

    // Next address; the sum wraps modulo 2^ADDR_WIDTH by design.
    always_comb begin
        addr_d   = addr_q;
        stride_d = stride_q;
        if (load_i) begin
            addr_d   = base_i;
            stride_d = stride_i;
        end else if (step_i) begin
            addr_d = addr_q + stride_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q   <= '0;
            stride_q <= '0;
        end else begin
            addr_q   <= addr_d;
            stride_q <= stride_d;
        end
    end

    assign addr_o = addr_q;

endmodule

// File: rtl/v_lane_mem_ctrl.sv
// Memory-side controller for one vector lane. Streams strided loads from
// memory into the lane load FIFO and drains the lane store FIFO into strided
// memory writes.
// Ports:
//   req_*            : request handshake (valid/ready), type, base, stride, length
//   done_o           : one-cycle completion pulse
//   mem_*            : memory command (addr/re/we/wdata/ready) and in-order read return
//   load_fifo_we_o,
//   data_from_mem_o  : registered push into the lane load FIFO
//   load_fifo_almostfull_i : throttles read issue
//   store_fifo_re_o  : pop strobe to the lane store FIFO
//   data_to_mem_i    : store FIFO data, valid the cycle after the pop
//   store_fifo_empty_i : store FIFO empty flag
module v_lane_mem_ctrl #(
    parameter int unsigned  DATA_WIDTH      = configurations_pkg::DATA_WIDTH,
    parameter int unsigned  VECTOR_LENGTH   = configurations_pkg::VECTOR_LENGTH,
    parameter int unsigned  ADDR_WIDTH      = 32,
    parameter int unsigned  MAX_OUTSTANDING = configurations_pkg::MAX_OUTSTANDING_DEF,
    localparam int unsigned LEN_W           = configurations_pkg::len_width(VECTOR_LENGTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_store_i,
    input  logic [ADDR_WIDTH-1:0] req_base_addr_i,
    input  logic [ADDR_WIDTH-1:0] req_stride_i,
    input  logic [LEN_W-1:0]      req_len_i,
    output logic                  done_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic                  mem_re_o,
    output logic                  mem_we_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic                  mem_ready_i,
    input  logic                  mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic                  load_fifo_we_o,
    output logic [DATA_WIDTH-1:0] data_from_mem_o,
    input  logic                  load_fifo_almostfull_i,
    output logic                  store_fifo_re_o,
    input  logic [DATA_WIDTH-1:0] data_to_mem_i,
    input  logic                  store_fifo_empty_i
);

    import configurations_pkg::*;

    localparam logic [LEN_W-1:0] MAX_OUT = LEN_W'(MAX_OUTSTANDING);
    localparam logic [LEN_W-1:0] ONE     = LEN_W'(1);

    mem_ctrl_state_t state_q, state_d;

    logic [LEN_W-1:0]      len_q, len_d;
    logic [LEN_W-1:0]      issued_q, issued_d;
    logic [LEN_W-1:0]      received_q, received_d;
    logic [LEN_W-1:0]      outstanding_q, outstanding_d;
    logic [LEN_W-1:0]      written_q, written_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] data_from_mem_q, data_from_mem_d;
    logic                  load_fifo_we_q, load_fifo_we_d;

    logic                  addr_load;
    logic                  addr_step;
    logic                  rd_fire;
    logic                  rd_return;
    logic [ADDR_WIDTH-1:0] cur_addr;

    v_mem_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_addr_gen (
        .clk      (clk),
        .reset    (reset),
        .load_i   (addr_load),
        .step_i   (addr_step),
        .base_i   (req_base_addr_i),
        .stride_i (req_stride_i),
        .addr_o   (cur_addr)
    );

    // Next-state, counters and command decode.
    always_comb begin
        state_d         = state_q;
        len_d           = len_q;
        issued_d        = issued_q;
        received_d      = received_q;
        outstanding_d   = outstanding_q;
        written_d       = written_q;
        wdata_d         = wdata_q;
        addr_load       = 1'b0;
        addr_step       = 1'b0;
        rd_fire         = 1'b0;
        req_ready_o     = 1'b0;
        done_o          = 1'b0;
        mem_re_o        = 1'b0;
        mem_we_o        = 1'b0;
        store_fifo_re_o = 1'b0;

        // Returns only count while a load is in flight; stray data is dropped.
        rd_return       = (state_q == LOAD) && mem_rvalid_i;
        load_fifo_we_d  = rd_return;
        data_from_mem_d = rd_return ? mem_rdata_i : data_from_mem_q;

        case (state_q)
            IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    addr_load     = 1'b1;
                    len_d         = req_len_i;
                    issued_d      = '0;
                    received_d    = '0;
                    outstanding_d = '0;
                    written_d     = '0;
                    if (req_len_i == '0) begin
                        state_d = DONE;
                    end else if (req_store_i) begin
                        state_d = ST_POP;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end

            LOAD: begin
                if ((issued_q < len_q) && (outstanding_q < MAX_OUT) &&
                    !load_fifo_almostfull_i) begin
                    mem_re_o = 1'b1;
                end
                rd_fire = mem_re_o && mem_ready_i;
                if (rd_fire) begin
                    addr_step = 1'b1;
                    issued_d  = issued_q + ONE;
                end
                // Issue and return in the same cycle cancel out.
                case ({rd_fire, rd_return})
                    2'b10:   outstanding_d = outstanding_q + ONE;
                    2'b01:   outstanding_d = outstanding_q - ONE;
                    default: outstanding_d = outstanding_q;
                endcase
                if (rd_return) begin
                    received_d = received_q + ONE;
                end
                // Last element has already been pushed to the FIFO this cycle.
                if (received_q == len_q) begin
                    state_d = DONE;
                end
            end

            ST_POP: begin
                if (!store_fifo_empty_i) begin
                    store_fifo_re_o = 1'b1;
                    state_d         = ST_WAIT;
                end
            end

            ST_WAIT: begin
                wdata_d = data_to_mem_i;
                state_d = ST_WRITE;
            end

            ST_WRITE: begin
                mem_we_o = 1'b1;
                if (mem_ready_i) begin
                    addr_step = 1'b1;
                    written_d = written_q + ONE;
                    state_d   = (written_d == len_q) ? DONE : ST_POP;
                end
            end

            DONE: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            len_q           <= '0;
            issued_q        <= '0;
            received_q      <= '0;
            outstanding_q   <= '0;
            written_q       <= '0;
            wdata_q         <= '0;
            data_from_mem_q <= '0;
            load_fifo_we_q  <= 1'b0;
        end else begin
            state_q         <= state_d;
            len_q           <= len_d;
            issued_q        <= issued_d;
            received_q      <= received_d;
            outstanding_q   <= outstanding_d;
            written_q       <= written_d;
            wdata_q         <= wdata_d;
            data_from_mem_q <= data_from_mem_d;
            load_fifo_we_q  <= load_fifo_we_d;
        end
    end

    assign mem_addr_o      = cur_addr;
    assign mem_wdata_o     = wdata_q;
    assign load_fifo_we_o  = load_fifo_we_q;
    assign data_from_mem_o = data_from_mem_q;

endmodule
